// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: sends one shadowed character on SOUT as start, data, parity and stop bits, LSB first.
// Latency: the start bit appears the CLK after TXSTART is accepted in IDLE; each bit lasts OVERSAMPLE TXCLK strobes.
// Backpressure: none; TXSTART is sampled only while TXFINISHED is high, so the caller holds it until then.
module uart_tx_serializer #(
  parameter int OVERSAMPLE = 16,  // even, >= 4
  parameter int DWIDTH     = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              TXCLK,
  input  logic              TXSTART,
  input  logic              CLEAR,
  input  logic [1:0]        WLS,
  input  logic              STB,
  input  logic              PEN,
  input  logic              EPS,
  input  logic              SP,
  input  logic              BC,
  input  logic [DWIDTH-1:0] DIN,
  output logic              TXFINISHED,
  output logic              SOUT
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DWIDTH);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4,
    STOP2 = 3'd5
  } state_t;

  state_t            state, state_nx;
  logic [TW-1:0]     tick, tick_nx, last_tick;
  logic [BW-1:0]     bitcnt, bitcnt_nx, last_bit;
  logic              load;
  logic              par_x, par_bit, level_nx;

  // Frame configuration captured at acceptance so input changes cannot disturb the frame in flight.
  logic [DWIDTH-1:0] sh_din;
  logic [1:0]        sh_wls;
  logic              sh_stb, sh_pen, sh_eps, sh_sp;

  assign TXFINISHED = (state == IDLE);
  assign last_bit   = BW'(int'(sh_wls) + 4);

  // Next state and counters: advance only on TXCLK strobes, wrap the tick counter at the end of each bit.
  always_comb begin
    state_nx  = state;
    tick_nx   = tick;
    bitcnt_nx = bitcnt;
    load      = 1'b0;
    // The second stop bit of a 5-bit frame is only half a bit long (1.5 stop bits total).
    last_tick = (state == STOP2 && sh_wls == 2'b00) ? HALF_LAST : FULL_LAST;
    if (state == IDLE) begin
      // A strobe coinciding with acceptance is deliberately not counted toward the start bit.
      if (TXSTART) begin
        load     = 1'b1;
        state_nx = START;
        tick_nx  = '0;
      end
    end else if (TXCLK) begin
      if (tick == last_tick) begin
        tick_nx = '0;
        case (state)
          START: begin
            state_nx  = DATA;
            bitcnt_nx = '0;
          end
          DATA: begin
            if (bitcnt == last_bit) state_nx = sh_pen ? PAR : STOP;
            else                    bitcnt_nx = bitcnt + BW'(1);
          end
          PAR:     state_nx = STOP;
          STOP:    state_nx = sh_stb ? STOP2 : IDLE;
          STOP2:   state_nx = IDLE;
          default: state_nx = IDLE;
        endcase
      end else begin
        tick_nx = tick + TW'(1);
      end
    end
    // Abort wins over everything, including a simultaneous TXSTART.
    if (CLEAR) begin
      state_nx  = IDLE;
      tick_nx   = '0;
      bitcnt_nx = '0;
      load      = 1'b0;
    end
  end

  // Parity over only the data bits actually sent; stick parity replaces it with ~EPS.
  always_comb begin
    par_x = 1'b0;
    for (int i = 0; i < DWIDTH; i++) begin
      if (i < 5 + int'(sh_wls)) par_x = par_x ^ sh_din[i];
    end
    par_bit = sh_sp ? ~sh_eps : (par_x ^ ~sh_eps);
  end

  // Line level for the state being entered, so SOUT can be registered without a cycle of lag.
  always_comb begin
    case (state_nx)
      START:   level_nx = 1'b0;
      DATA:    level_nx = sh_din[bitcnt_nx];
      PAR:     level_nx = par_bit;
      default: level_nx = 1'b1;
    endcase
  end

  // State, counters and registered serial output; break forces the line low without stopping the timing.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      tick   <= '0;
      bitcnt <= '0;
      SOUT   <= 1'b1;
    end else begin
      state  <= state_nx;
      tick   <= tick_nx;
      bitcnt <= bitcnt_nx;
      SOUT   <= BC ? 1'b0 : level_nx;
    end
  end

  // Shadow register loads once per frame, on acceptance.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sh_din <= '0;
      sh_wls <= 2'b00;
      sh_stb <= 1'b0;
      sh_pen <= 1'b0;
      sh_eps <= 1'b0;
      sh_sp  <= 1'b0;
    end else if (load) begin
      sh_din <= DIN;
      sh_wls <= WLS;
      sh_stb <= STB;
      sh_pen <= PEN;
      sh_eps <= EPS;
      sh_sp  <= SP;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: per-strobe SOUT trace of each frame against a frame model.
// TXCLK strobes every PER cycles; frames are normally accepted on a strobe cycle.
// Aborted frames are discarded by the monitor; BC-covered strobes are masked from the trace compare.
module tb_uart_tx_serializer;
  localparam int PER = 4;
  localparam int OS  = 16;

  logic       clk = 1'b0, rst = 1'b1, txclk = 1'b0, txstart = 1'b0, clear = 1'b0;
  logic       stb = 1'b0, pen = 1'b0, eps = 1'b0, sp = 1'b0, bc = 1'b0;
  logic [1:0] wls = 2'b11;
  logic [7:0] din = 8'h00;
  logic       txfinished, sout;

  int n_chk = 0, n_pass = 0;

  typedef struct {
    logic [255:0] bits;
    int           len;
    int           cyc;
  } frame_t;
  frame_t sb[$];

  logic [255:0] tr = '0, msk = '0;
  int   tn = 0, tcyc = 0, hi_run = 0, last_gap = 0, bc_bad = 0;
  logic prev_fin = 1'b1, bc_prev = 1'b0, discard = 1'b0;

  uart_tx_serializer #(.OVERSAMPLE(OS), .DWIDTH(8)) dut (
    .CLK(clk), .RST(rst), .TXCLK(txclk), .TXSTART(txstart), .CLEAR(clear),
    .WLS(wls), .STB(stb), .PEN(pen), .EPS(eps), .SP(sp), .BC(bc), .DIN(din),
    .TXFINISHED(txfinished), .SOUT(sout)
  );

  always #5 clk = ~clk;

  // Baud strobe: one cycle high every PER cycles.
  initial begin
    int div;
    div = 0;
    forever begin
      @(posedge clk);
      #1;
      div   = (div + 1) % PER;
      txclk = (div == 0);
    end
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Expected per-strobe line level for one frame.
  function automatic void build(input logic [7:0] d, input logic [1:0] w,
                                input logic s, input logic p, input logic e, input logic k,
                                output logic [255:0] b, output int len);
    int   nd, nstop;
    logic x, par;
    nd  = 5 + int'(w);
    b   = '0;
    len = OS;
    x   = 1'b0;
    for (int i = 0; i < nd; i++) begin
      for (int j = 0; j < OS; j++) b[len + j] = d[i];
      len += OS;
      x = x ^ d[i];
    end
    if (p) begin
      par = k ? ~e : (e ? x : ~x);
      for (int j = 0; j < OS; j++) b[len + j] = par;
      len += OS;
    end
    for (int j = 0; j < OS; j++) b[len + j] = 1'b1;
    len += OS;
    if (s) begin
      nstop = (w == 2'b00) ? OS / 2 : OS;
      for (int j = 0; j < nstop; j++) b[len + j] = 1'b1;
      len += nstop;
    end
  endfunction

  task automatic cfg(input logic [7:0] d, input logic [1:0] w,
                     input logic s, input logic p, input logic e, input logic k);
    din = d; wls = w; stb = s; pen = p; eps = e; sp = k;
  endtask

  task automatic push_exp(input int adj);
    frame_t f;
    build(din, wls, stb, pen, eps, sp, f.bits, f.len);
    f.cyc = f.len * PER + adj;
    sb.push_back(f);
  endtask

  // Raise TXSTART for exactly the cycle that carries a TXCLK strobe.
  task automatic start_aligned();
    @(posedge clk); #2;
    while (!txclk) begin @(posedge clk); #2; end
    txstart = 1'b1;
    @(posedge clk); #2;
    txstart = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!txfinished && n < 3000) begin @(negedge clk); n++; end
    chk(tag, 256'(txfinished), 256'(1));
    repeat (2) @(negedge clk);
  endtask

  // Monitor: record SOUT on every strobe of a frame; compare when TXFINISHED rises.
  always @(negedge clk) begin
    frame_t e;
    if (bc && bc_prev && sout) bc_bad++;
    if (!txfinished) begin
      if (prev_fin) begin
        tr = '0; msk = '0; tn = 0; tcyc = 0; last_gap = hi_run;
      end
      tcyc++;
      if (txclk && tn < 256) begin
        tr[tn]  = sout;
        msk[tn] = !(bc || bc_prev);
        tn++;
      end
      hi_run = 0;
    end else begin
      if (!prev_fin) begin
        if (discard) begin
          discard = 1'b0;
        end else begin
          chk("frame_expected", 256'(sb.size() > 0), 256'(1));
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("frame_len", 256'(tn), 256'(e.len));
            chk("frame_bits", tr & msk, e.bits & msk);
            chk("frame_cycles", 256'(tcyc), 256'(e.cyc));
          end
        end
      end
      hi_run++;
    end
    prev_fin = txfinished;
    bc_prev  = bc;
  end

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_sout", 256'(sout), 256'(1));
    chk("rst_txfinished", 256'(txfinished), 256'(1));
    @(posedge clk); #2;
    rst = 1'b0;

    // 8N1 0x55: 10 bits, 640 cycles with TXFINISHED low
    cfg(8'h55, 2'b11, 0, 0, 0, 0); push_exp(0); start_aligned(); wait_idle("done_8n1");

    // Parity variants
    cfg(8'hFF, 2'b10, 0, 1, 1, 0); push_exp(0); start_aligned(); wait_idle("done_7e1");
    cfg(8'hFF, 2'b10, 0, 1, 0, 0); push_exp(0); start_aligned(); wait_idle("done_7o1");
    cfg(8'hFF, 2'b10, 0, 1, 1, 1); push_exp(0); start_aligned(); wait_idle("done_stick1");
    cfg(8'hFF, 2'b10, 0, 1, 0, 1); push_exp(0); start_aligned(); wait_idle("done_stick0");
    cfg(8'h1F, 2'b00, 0, 1, 1, 0); push_exp(0); start_aligned(); wait_idle("done_5e1");

    // Stop-bit lengths: 1.5 for 5-bit words, 2 otherwise
    cfg(8'h0A, 2'b00, 1, 0, 0, 0); push_exp(0); start_aligned(); wait_idle("done_5n2");
    cfg(8'hC3, 2'b11, 1, 0, 0, 0); push_exp(0); start_aligned(); wait_idle("done_8n2");

    // Input changes after acceptance must not affect the frame in flight
    cfg(8'h2A, 2'b01, 1, 0, 0, 0); push_exp(0); start_aligned();
    cfg(8'hFF, 2'b11, 0, 1, 1, 0); wait_idle("done_shadow");

    // Back-to-back frames with TXSTART held
    begin
      int n;
      cfg(8'hA5, 2'b11, 0, 0, 0, 0); push_exp(0);
      @(posedge clk); #2;
      while (!txclk) begin @(posedge clk); #2; end
      txstart = 1'b1;
      @(posedge clk); #2;
      din = 8'h3C; push_exp(-1);
      n = 0;
      @(negedge clk);
      while (!txfinished && n < 3000) begin @(negedge clk); n++; end
      chk("b2b_first_done", 256'(txfinished), 256'(1));
      @(posedge clk); #2;
      txstart = 1'b0;
      wait_idle("done_b2b");
      chk("b2b_gap", 256'(last_gap), 256'(1));
    end

    // Break in the middle of data bit 2, released inside data bit 3 (0x0D: b2=1, b3=1)
    cfg(8'h0D, 2'b11, 0, 0, 0, 0); push_exp(0); start_aligned();
    bc_bad = 0;
    repeat (212) @(posedge clk); #2;
    bc = 1'b1;
    repeat (100) @(posedge clk); #2;
    bc = 1'b0;
    repeat (2) @(negedge clk);
    chk("bc_release_bit3", 256'(sout), 256'(1));
    chk("bc_held_low", 256'(bc_bad), 256'(0));
    wait_idle("done_bc");

    // CLEAR in the parity bit of 7E1 0x03 (parity 0)
    cfg(8'h03, 2'b10, 0, 1, 1, 0);
    discard = 1'b1;
    start_aligned();
    repeat (530) @(posedge clk);
    @(negedge clk);
    chk("par_before_clear", 256'(sout), 256'(0));
    @(posedge clk); #2;
    clear = 1'b1;
    @(posedge clk); #2;
    clear = 1'b0;
    @(negedge clk);
    chk("clear_sout", 256'(sout), 256'(1));
    chk("clear_txfinished", 256'(txfinished), 256'(1));
    @(posedge clk); #2;
    clear = 1'b1; txstart = 1'b1;
    @(posedge clk); #2;
    clear = 1'b0; txstart = 1'b0;
    @(negedge clk);
    chk("clear_beats_start", 256'(txfinished), 256'(1));
    push_exp(0); start_aligned(); wait_idle("done_after_clear");

    // Asynchronous reset during data bit 1 (0x0D: b1=0)
    cfg(8'h0D, 2'b11, 0, 0, 0, 0);
    discard = 1'b1;
    start_aligned();
    repeat (150) @(posedge clk); #3;
    chk("pre_rst_low", 256'(sout), 256'(0));
    rst = 1'b1;
    #1;
    chk("rst_async_sout", 256'(sout), 256'(1));
    chk("rst_async_txfinished", 256'(txfinished), 256'(1));
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    cfg(8'h5A, 2'b11, 0, 1, 0, 0); push_exp(0); start_aligned(); wait_idle("done_after_rst");

    chk("sb_drain", 256'(sb.size()), 256'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Transmit-side serializer for the 16750-compatible APB UART; the counterpart of the receive path and its input filter.
- Takes one parallel character from the THR/TX FIFO and shifts it onto SOUT LSB-first as start, data, optional parity and stop bits.
- Bit timing is derived from the baud generator's oversampling enable strobe.
- Reports completion so the register block can pop the next character and raise THRE/TEMT.

Parameters:
OVERSAMPLE, 16, TXCLK strobes per serial bit; must be even and >= 4
DWIDTH, 8, maximum data bits; fixed at 8 for 16750 compatibility

Ports:
CLK  input  1  system clock
RST  input  1  reset
TXCLK  input  1  baud enable strobe, one CLK cycle wide, OVERSAMPLE per bit period
TXSTART  input  1  request to send DIN; level, sampled only in IDLE
CLEAR  input  1  synchronous abort, returns the block to IDLE
WLS  input  2  word length: 00=5, 01=6, 10=7, 11=8 data bits
STB  input  1  0=1 stop bit; 1=2 stop bits (1.5 when WLS=00)
PEN  input  1  parity enable
EPS  input  1  even parity select
SP  input  1  stick parity
BC  input  1  break control; forces SOUT low
DIN  input  8  character to send
TXFINISHED  output  1  high while IDLE (no character in flight)
SOUT  output  1  serial output, registered

Behaviour:
- Reset: asynchronous, active-high on RST; clock CLK. Reset values: state=IDLE, SOUT=1, TXFINISHED=1, tick counter=0, bit counter=0.
- States: IDLE, START, DATA, PAR, STOP, STOP2.
- IDLE: SOUT=1 and TXFINISHED=1. If TXSTART=1 on a CLK edge:
  - Latch DIN, WLS, STB, PEN, EPS and SP into a shadow register; later input changes do not affect the frame in flight.
  - Clear the tick counter and go to START.
  - TXFINISHED=0 from the next cycle.
- Bit timing: the tick counter increments only on CLK edges with TXCLK=1. A bit ends on the edge where the counter would reach OVERSAMPLE; the counter then wraps to 0 and the state or bit advances. The first bit therefore lasts exactly OVERSAMPLE strobes after acceptance.
- START: SOUT=0 for 1 bit, then DATA with bit counter=0.
- DATA: SOUT=shadow[bitcnt], LSB first. Sends 5+WLS bits. After the last bit, go to PAR if PEN=1, otherwise STOP.
- PAR parity bit:
  - SP=0, EPS=1: XOR of the sent data bits (even total).
  - SP=0, EPS=0: inverted XOR (odd).
  - SP=1: the bit is ~EPS.
  - Only the bits actually sent (5+WLS) contribute.
- STOP: SOUT=1 for 1 bit. Then:
  - STB=0: go to IDLE.
  - STB=1, WLS!=00: STOP2 for a full bit.
  - STB=1, WLS=00: STOP2 for OVERSAMPLE/2 strobes.
- Back-to-back frames: the return to IDLE takes one CLK. If TXSTART is still high, the next frame starts on the following edge. TXFINISHED is high for at least one cycle between frames, and the register block uses that rising edge as its pop strobe.
- SOUT is registered and glitch-free. It changes only on state or bit advance and on BC edges.
- BC=1: SOUT=0 regardless of state, while the frame continues timing normally underneath. When BC is released, SOUT resumes the current state's value on the next CLK.
- CLEAR=1: on the next edge go to IDLE, SOUT=1, TXFINISHED=1, counters cleared. The aborted frame is lost. CLEAR beats TXSTART when both are asserted in the same cycle.
- TXCLK with TXSTART in the same IDLE cycle: the strobe is not counted toward the start bit.
- RST mid-frame: immediate return to reset values; SOUT goes high asynchronously.
- No other handshake exists. A TXSTART that arrives while the block is not in IDLE is ignored; the register block must hold it until TXFINISHED is high.

Test Plan:
- 8N1, DIN=0x55, OVERSAMPLE=16, TXCLK every 4 CLK → SOUT low for 64 CLK, then 1,0,1,0,1,0,1,0 at 64 CLK each, then 1 stop bit. TXFINISHED low for 640 CLK after acceptance, then rises.
- 7E1, DIN=0xFF (bit7 ignored) → 7 ones, parity=1; 7O1 → parity=0; stick with EPS=1 → 0, EPS=0 → 1; 5-bit with DIN=0x1F → parity=1 when even parity is selected.
- 5 data bits, STB=1 → stop period exactly 24 strobes; 8 data bits, STB=1 → 32 strobes; STB toggled mid-frame after acceptance → no change to the frame.
- Back-to-back: TXSTART held high with DIN 0xA5 then 0x3C → two frames, a TXFINISHED pulse of 1 cycle between them, no extra idle bit beyond that single CLK.
- BC asserted in the middle of a DATA bit for 100 CLK → SOUT=0 throughout, frame length unchanged; after release SOUT shows the current bit.
- CLEAR mid-PAR → next cycle SOUT=1 and TXFINISHED=1; a new TXSTART then sends a clean full frame. RST pulse mid-DATA → SOUT=1 immediately.
